adaptive_signal_ctrl: RTL

- Demand-responsive traffic-signal controller for one intersection.
- Sits directly downstream of `carcnt` and consumes its per-approach queue counts.
- Sequences the north-south (NS) and east-west (EW) signal heads. Each green lasts longer when more cars are queued, and ends early when its own approach is empty but the other approach is waiting.
- Outputs the light codes plus an 8-bit seconds-remaining countdown. The countdown is in the format `display_digit` takes on `data_value`, so VGA can show it directly.

---
 rtl/adaptive_signal_ctrl.sv | 76 +++++++
 1 files changed

// File: rtl/adaptive_signal_ctrl.sv
// adaptive_signal_ctrl: demand-responsive two-phase traffic signal controller with tick-based countdown
module adaptive_signal_ctrl #(
  parameter int TICK_DIV   = 25_000_000,
  parameter int GREEN_MIN  = 10,
  parameter int GREEN_MAX  = 40,
  parameter int YELLOW_T   = 3,
  parameter int ALLRED_T   = 1,
  parameter int CAR_WEIGHT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] q_ns_a,
  input  logic [7:0] q_ns_b,
  input  logic [7:0] q_ew_a,
  input  logic [7:0] q_ew_b,
  output logic [1:0] ns_light,
  output logic [1:0] ew_light,
  output logic [7:0] countdown,
  output logic [2:0] phase,
  output logic       tick
);
  typedef enum logic [2:0] {AR_NS, NS_G, NS_Y, AR_EW, EW_G, EW_Y} state_t;
  localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  state_t state, nxt_state;
  logic [PW-1:0] pre;
  logic [7:0] elapsed, nxt_cd;
  logic [8:0] ns_sum, ew_sum, own, other;
  logic [1:0] ns_nxt, ew_nxt;
  logic gap, adv;
  // saturating green length; 32-bit math so 255*weight never wraps
  function automatic logic [7:0] green(input logic [8:0] d);
    logic [31:0] t;
    t = 32'(GREEN_MIN) + 32'(CAR_WEIGHT) * 32'(d);
    return t > 32'(GREEN_MAX) ? 8'(GREEN_MAX) : t[7:0];
  endfunction
  assign phase = state;
  // demand sums, gap-out decision and the phase that follows the current one
  always_comb begin
    ns_sum    = 9'(q_ns_a) + 9'(q_ns_b);
    ew_sum    = 9'(q_ew_a) + 9'(q_ew_b);
    own       = state == EW_G ? ew_sum : ns_sum;
    other     = state == EW_G ? ns_sum : ew_sum;
    gap       = (state == NS_G || state == EW_G) && 32'(elapsed) + 32'd1 >= 32'(GREEN_MIN) && own == '0 && other != '0;
    adv       = gap || countdown <= 8'd1 || state > EW_Y;
    nxt_state = (state >= EW_Y) ? AR_NS : state_t'(state + 3'd1);
    nxt_cd    = nxt_state == NS_G ? green(ns_sum) : nxt_state == EW_G ? green(ew_sum) :
                (nxt_state == NS_Y || nxt_state == EW_Y) ? 8'(YELLOW_T) : 8'(ALLRED_T);
    ns_nxt    = nxt_state == NS_G ? 2'b10 : nxt_state == NS_Y ? 2'b01 : 2'b00;
    ew_nxt    = nxt_state == EW_G ? 2'b10 : nxt_state == EW_Y ? 2'b01 : 2'b00;
  end
  // prescaler plus phase sequencing, all outputs registered and moving only on tick
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= AR_NS;
      ns_light  <= 2'b00;
      ew_light  <= 2'b00;
      countdown <= 8'(ALLRED_T);
      pre       <= '0;
      tick      <= 1'b0;
      elapsed   <= '0;
    end else begin
      tick <= pre == PW'(TICK_DIV - 1);
      pre  <= pre == PW'(TICK_DIV - 1) ? '0 : pre + 1'b1;
      if (tick && adv) begin
        state     <= nxt_state;
        countdown <= nxt_cd;
        elapsed   <= '0;
        ns_light  <= ns_nxt;
        ew_light  <= ew_nxt;
      end else if (tick) begin
        countdown <= countdown - 8'd1;
        elapsed   <= elapsed + 8'd1;
      end
    end
  end
endmodule
